// File: rtl/peripheral_operand_loader_if.sv
// Byte-stream and operand-pair bus for peripheral_operand_loader.
//   byte_i / byte_valid_i / byte_ready_o : incoming byte stream handshake
//   datainput_o                          : index (0..7) of the next byte slot
//   dataA_o / dataB_o                    : assembled operands (bytes 0..3 / 4..7)
//   op_valid_o / op_ready_i              : operand pair handshake to downstream
// Modports: master = stream source / operand consumer, slave = loader.
interface peripheral_operand_loader_if;
   logic [7:0]  byte_i;
   logic        byte_valid_i;
   logic        byte_ready_o;
   logic [3:0]  datainput_o;
   logic [31:0] dataA_o;
   logic [31:0] dataB_o;
   logic        op_valid_o;
   logic        op_ready_i;

   modport master (
      output byte_i, byte_valid_i, op_ready_i,
      input  byte_ready_o, datainput_o, dataA_o, dataB_o, op_valid_o
   );

   modport slave (
      input  byte_i, byte_valid_i, op_ready_i,
      output byte_ready_o, datainput_o, dataA_o, dataB_o, op_valid_o
   );
endinterface

// File: rtl/peripheral_operand_loader.sv
// Byte-stream front end for the operand path: collects eight bytes into two
// little-endian 32-bit operands and offers the pair downstream.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus         : peripheral_operand_loader_if.slave (byte stream + operand pair)
//   clear_i     : synchronous abort of the current packet (highest priority)
//   busy_o      : at least one byte of the current packet held
//   timeout_o   : one-cycle pulse on a mid-packet idle timeout abort
// Optional feature: define OPLOAD_TIMEOUT_EN to abort a packet after
// TIMEOUT_CYCLES consecutive idle cycles in LOAD; otherwise timeout_o is 0.
module peripheral_operand_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   peripheral_operand_loader_if.slave  bus,
   input  logic                        clear_i,
   output logic                        busy_o,
   output logic                        timeout_o
);

   localparam int unsigned IDX_W  = 3;
   localparam int unsigned DATA_W = 64;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_FULL = 2'd2;

   // A zero timeout would abort every packet before its first idle cycle.
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              accept;

   // Ready depends on the live clear_i so an aborting cycle never takes a byte.
   assign bus.byte_ready_o = (state_q != ST_FULL) && !clear_i;
   assign accept           = bus.byte_valid_i && bus.byte_ready_o;

   assign bus.datainput_o = {1'b0, idx_q};
   assign bus.dataA_o     = data_q[31:0];
   assign bus.dataB_o     = data_q[63:32];
   assign bus.op_valid_o  = (state_q == ST_FULL);
   assign busy_o          = (state_q != ST_IDLE);

`ifdef OPLOAD_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         data_q    <= '0;
`ifdef OPLOAD_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
`ifdef OPLOAD_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      data_d    = data_q;
`ifdef OPLOAD_TIMEOUT_EN
      cnt_d     = '0;
      timeout_d = 1'b0;
`endif

      if (clear_i) begin
         // Data is left stale on abort; only op_valid_o qualifies it.
         state_d = ST_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  data_d[{idx_q, 3'b000} +: 8] = bus.byte_i;
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  data_d[{idx_q, 3'b000} +: 8] = bus.byte_i;
                  idx_d = idx_q + IDX_W'(1);   // wraps 7 -> 0 on the last byte
                  if (idx_q == IDX_W'(7)) begin
                     state_d = ST_FULL;
                  end
               end
`ifdef OPLOAD_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  // This idle cycle is the TIMEOUT_CYCLES-th in a row.
                  state_d   = ST_IDLE;
                  idx_d     = '0;
                  timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`endif
            end
            ST_FULL: begin
               if (bus.op_ready_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_peripheral_operand_loader.sv
// Self-checking bench for peripheral_operand_loader: directed steps followed
// by a randomized stream, compared against a packet-level reference model.
module tb_peripheral_operand_loader;

   localparam int unsigned TO_CYCLES = 4;

   logic clk;
   logic rst_n;
   logic clear_i;
   logic busy_o;
   logic timeout_o;

   peripheral_operand_loader_if bus ();

   peripheral_operand_loader #(
      .TIMEOUT_CYCLES (TO_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .clear_i   (clear_i),
      .busy_o    (busy_o),
      .timeout_o (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: bytes held in the current packet and the slot contents.
   logic [7:0] mb [8];
   int         mcnt;
   int         midle;
   bit         mto;

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) mb[i] = 8'h00;
      mcnt  = 0;
      midle = 0;
      mto   = 1'b0;
   endfunction

   function automatic void model_step(bit v, logic [7:0] b, bit clr, bit rdy);
      mto = 1'b0;
      if (clr) begin
         mcnt  = 0;
         midle = 0;
      end else if (mcnt == 8) begin
         if (rdy) mcnt = 0;
      end else if (v) begin
         mb[mcnt] = b;
         mcnt++;
         midle = 0;
      end else if (mcnt > 0) begin
         midle++;
`ifdef OPLOAD_TIMEOUT_EN
         if (midle == int'(TO_CYCLES)) begin
            mcnt  = 0;
            midle = 0;
            mto   = 1'b1;
         end
`endif
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("datainput", 64'(bus.datainput_o), 64'(mcnt % 8));
      chk("dataA", 64'(bus.dataA_o), 64'({mb[3], mb[2], mb[1], mb[0]}));
      chk("dataB", 64'(bus.dataB_o), 64'({mb[7], mb[6], mb[5], mb[4]}));
      chk("op_valid", 64'(bus.op_valid_o), 64'(mcnt == 8));
      chk("busy", 64'(busy_o), 64'(mcnt > 0));
      chk("timeout", 64'(timeout_o), 64'(mto));
   endtask

   // One clock cycle: present inputs, check ready, clock, update model, check.
   task automatic drive(input bit v, input logic [7:0] b, input bit clr, input bit rdy);
      bus.byte_valid_i = v;
      bus.byte_i       = b;
      clear_i          = clr;
      bus.op_ready_i   = rdy;
      #1;
      chk("byte_ready", 64'(bus.byte_ready_o), 64'((mcnt != 8) && !clr));
      @(posedge clk);
      model_step(v, b, clr, rdy);
      #1;
      check_outputs();
   endtask

   initial begin
      bus.byte_i       = 8'h00;
      bus.byte_valid_i = 1'b0;
      bus.op_ready_i   = 1'b0;
      clear_i          = 1'b0;
      rst_n            = 1'b0;
      model_reset();

      // Reset values
      #12;
      check_outputs();
      chk("reset_ready", 64'(bus.byte_ready_o), 64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outputs();

      // Full packet 0x11..0x88, held without op_ready
      for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
      chk("pkt1_valid", 64'(bus.op_valid_o), 64'd1);
      chk("pkt1_A", 64'(bus.dataA_o), 64'h44332211);
      chk("pkt1_B", 64'(bus.dataB_o), 64'h88776655);
      repeat (20) drive(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("pkt1_hold_A", 64'(bus.dataA_o), 64'h44332211);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("pkt1_drop_valid", 64'(bus.op_valid_o), 64'd0);
      chk("pkt1_idx0", 64'(bus.datainput_o), 64'd0);

      // Gaps between bytes; byte offered during handshake must be refused
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
         repeat ($urandom_range(0, 3)) drive(1'b0, 8'h00, 1'b0, 1'b0);
      end
      drive(1'b1, 8'h5A, 1'b0, 1'b1);
      chk("hs_no_bypass_idx", 64'(bus.datainput_o), 64'd0);
      chk("hs_no_bypass_A", 64'(bus.dataA_o), 64'h23222120);
      drive(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("after_hs_idx", 64'(bus.datainput_o), 64'd1);
      chk("after_hs_A", 64'(bus.dataA_o), 64'h2322215A);
      drive(1'b0, 8'h00, 1'b1, 1'b0);

      // Abort after 3 bytes with a colliding byte, then a fresh packet
      for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      drive(1'b1, 8'hCC, 1'b1, 1'b0);
      chk("abort_idx", 64'(bus.datainput_o), 64'd0);
      chk("abort_busy", 64'(busy_o), 64'd0);
      for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      chk("pkt2_A", 64'(bus.dataA_o), 64'hA3A2A1A0);
      chk("pkt2_B", 64'(bus.dataB_o), 64'hA7A6A5A4);
      drive(1'b0, 8'h00, 1'b0, 1'b1);

      // Asynchronous reset in the cycle of the 5th byte
      for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
      bus.byte_valid_i = 1'b1;
      bus.byte_i       = 8'h35;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      chk("async_rst_A", 64'(bus.dataA_o), 64'd0);
      bus.byte_valid_i = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Idle timeout after 2 bytes
      drive(1'b1, 8'h61, 1'b0, 1'b0);
      drive(1'b1, 8'h62, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef OPLOAD_TIMEOUT_EN
         if (i == 3) chk("to_not_yet", 64'(timeout_o), 64'd0);
         if (i == 4) begin
            chk("to_pulse", 64'(timeout_o), 64'd1);
            chk("to_idle", 64'(busy_o), 64'd0);
         end
         if (i == 5) chk("to_one_cycle", 64'(timeout_o), 64'd0);
`endif
      end
`ifndef OPLOAD_TIMEOUT_EN
      chk("no_to_busy", 64'(busy_o), 64'd1);
      chk("no_to_pulse", 64'(timeout_o), 64'd0);
`endif
      drive(1'b0, 8'h00, 1'b1, 1'b0);

      // Randomized stream
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 3) != 0), 8'($urandom),
               ($urandom_range(0, 40) == 0), ($urandom_range(0, 2) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/peripheral_operand_loader.md
Name: peripheral_operand_loader

Overview:
- Byte-stream front end for the operand path.
- Accepts an 8-bit stream over a valid/ready handshake and tracks the write index for each byte.
- Assembles two 32-bit operands, then presents them to the downstream arithmetic stage with a valid/ready handshake.
- Produces the byte index and assembled words that the operand-splitting stage consumes. It also adds the sequencing, holding and flow control that stage lacks.

Parameters:
- TIMEOUT_CYCLES, 255: idle cycles tolerated mid-packet before abort; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- byte_i  input  8  incoming data byte
- byte_valid_i  input  1  byte_i valid
- byte_ready_o  output  1  loader can accept a byte this cycle
- clear_i  input  1  synchronous abort of the current packet
- datainput_o  output  4  index (0..7) of the next byte slot to be written
- dataA_o  output  32  operand A, bytes 0..3
- dataB_o  output  32  operand B, bytes 4..7
- op_valid_o  output  1  operand pair complete and stable
- op_ready_i  input  1  downstream consumes the pair
- busy_o  output  1  at least one byte of the current packet held
- timeout_o  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; datainput_o=0; dataA_o=0; dataB_o=0; op_valid_o=0; busy_o=0; timeout_o=0.
- FSM states:
  - IDLE: no bytes held.
  - LOAD: 1..7 bytes held.
  - FULL: 8 bytes held, pair offered downstream.
- byte_ready_o = (state != FULL) && !clear_i. It is combinational and carries no registered lag.
- Byte accept = byte_valid_i && byte_ready_o.
- On accept, byte k = datainput_o is written to 64-bit word {dataB,dataA} bits [8k+7:8k], little-endian:
  - byte 0 goes to dataA_o[7:0].
  - byte 4 goes to dataB_o[7:0].
- On accept, datainput_o increments.
- Transitions:
  - IDLE→LOAD on accept.
  - LOAD→FULL on accept of byte 7; datainput_o wraps to 0.
  - FULL→IDLE on op_valid_o && op_ready_i.
- op_valid_o = (state == FULL). It asserts the cycle after byte 7 is accepted.
- dataA_o and dataB_o stay stable while op_valid_o is high, and the loader never drops op_valid_o without a handshake except on clear_i.
- There is no bypass: a byte presented in the same cycle as the FULL handshake is not accepted. Minimum period is 9 cycles per pair.
- busy_o = (state == LOAD) || (state == FULL).
- clear_i (synchronous) in any state:
  - State goes to IDLE, datainput_o to 0, op_valid_o to 0.
  - dataA_o and dataB_o keep their values (stale, not valid).
  - clear_i has priority over a simultaneous byte accept or op handshake; neither takes effect.
- Unwritten byte slots of a new packet keep their previous contents until overwritten; consumers rely only on op_valid_o.
- Reset mid-packet discards all progress and zeroes the data immediately.

Optional Feature:
- Macro OPLOAD_TIMEOUT_EN, enabled:
  - In LOAD, an internal counter increments on every cycle without an accept and clears on each accept.
  - When it reaches TIMEOUT_CYCLES, the FSM behaves as on clear_i, and timeout_o pulses high for exactly that one cycle.
  - The counter is idle and held at 0 in IDLE and FULL; a FULL state waits indefinitely for op_ready_i.
- Macro not defined: no counter is built, timeout_o is tied 0, and LOAD waits indefinitely.

Test Plan:
- Reset values: hold rst_n=0, then release → all outputs 0 and byte_ready_o=1.
- Full packet: send bytes 0x11..0x88 back-to-back with op_ready_i=0 →
  - op_valid_o rises one cycle after the 8th byte.
  - dataA_o=0x44332211, dataB_o=0x88776655.
  - byte_ready_o=0 and data stable for 20 cycles.
  - Then op_ready_i=1 → op_valid_o falls next cycle and datainput_o=0.
- Gaps and index: insert idle cycles between bytes → datainput_o steps 0..7 only on accepts. Present byte_valid_i in the handshake cycle → that byte is not accepted, and is accepted in the following IDLE cycle as index 0.
- Abort: after 3 bytes assert clear_i together with byte_valid_i → byte not taken, datainput_o=0, busy_o=0. A fresh 8-byte packet 0xA0..0xA7 yields dataA_o=0xA3A2A1A0 and dataB_o=0xA7A6A5A4.
- Async reset mid-packet: pull rst_n low in the same cycle as the 5th byte → outputs zero immediately, with no clock edge needed.
- Timeout (OPLOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4): send 2 bytes, then idle →
  - Exactly 4 idle cycles later timeout_o pulses for 1 cycle and the state returns to IDLE.
  - Without the macro the same stimulus leaves busy_o=1 and timeout_o=0 indefinitely.
